// File: rtl/pipe_pkg.sv
// Shared constants and types for the inter-stage pipeline registers.
// The sideband struct lets payload and control travel as one buffer entry.
package pipe_pkg;

    localparam logic [31:0]           NOP_INST  = 32'h0000_0013;
    localparam int unsigned           REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0]  ZERO_REG  = '0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 we;
        logic                 is_load;
    } sideband_t;

    localparam int unsigned SIDEBAND_W = $bits(sideband_t);

    // A load that writes a real register and feeds either decode source.
    function automatic logic load_use_hit(input sideband_t            sb,
                                          input logic [REG_IDX_W-1:0] rs1,
                                          input logic [REG_IDX_W-1:0] rs2);
        return sb.is_load && sb.we && (sb.rd != ZERO_REG) &&
               ((sb.rd == rs1) || (sb.rd == rs2));
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready skid buffer: two entries with registered ready, or a
// single entry with combinational ready when SKID_EN = 0.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned  W       = 8,
    parameter bit           SKID_EN = 1'b1,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    occ_e         occ_q, occ_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         ready_q, ready_d;
    logic         in_fire, out_fire;

    assign out_valid_o = (occ_q != OCC_EMPTY);
    assign out_data_o  = head_q;
    assign in_ready_o  = SKID_EN ? ready_q : (!out_valid_o || out_ready_i);
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_o && out_ready_i;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        if (clr_i) begin
            occ_d  = OCC_EMPTY;
            head_d = CLR_VAL;
            skid_d = CLR_VAL;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        occ_d  = OCC_ONE;
                        head_d = in_data_i;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        head_d = in_data_i;
                    end else if (in_fire && SKID_EN) begin
                        occ_d  = OCC_TWO;
                        skid_d = in_data_i;
                    end else if (out_fire) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // Upstream is stalled here, so only a drain can happen.
                    if (out_fire) begin
                        occ_d  = OCC_ONE;
                        head_d = skid_q;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
        ready_d = (occ_d != OCC_TWO);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q   <= OCC_EMPTY;
            head_q  <= CLR_VAL;
            skid_q  <= CLR_VAL;
            ready_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: skid-buffered handshake, NOP bubble when
// empty, synchronous flush, load-use detection and a stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned          PAYLOAD_W = 128,
    parameter int unsigned          RD_W      = 5,
    parameter bit                   SKID_EN   = 1'b1,
    parameter logic [PAYLOAD_W-1:0] BUBBLE    = PAYLOAD_W'(NOP_INST),
    parameter int unsigned          CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_payload_i,
    input  logic [RD_W-1:0]      in_rd_i,
    input  logic                 in_we_i,
    input  logic                 in_is_load_i,
    input  logic                 flush_i,
    input  logic [RD_W-1:0]      rs1_i,
    input  logic [RD_W-1:0]      rs2_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_payload_o,
    output logic [RD_W-1:0]      out_rd_o,
    output logic                 out_we_o,
    output logic                 out_is_load_o,
    output logic                 load_use_o,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    localparam int unsigned            ENTRY_W   = PAYLOAD_W + SIDEBAND_W;
    localparam sideband_t              SB_ZERO   = '0;
    localparam logic [ENTRY_W-1:0]     ENTRY_CLR = {BUBBLE, SB_ZERO};

    sideband_t              sb_in, head_sb;
    logic [PAYLOAD_W-1:0]   head_payload;
    logic [ENTRY_W-1:0]     head_entry;
    logic                   head_valid;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

    always_comb begin
        sb_in         = SB_ZERO;
        sb_in.rd      = REG_IDX_W'(in_rd_i);
        sb_in.we      = in_we_i;
        sb_in.is_load = in_is_load_i;
    end

    pipe_skid_buf #(
        .W       (ENTRY_W),
        .SKID_EN (SKID_EN),
        .CLR_VAL (ENTRY_CLR)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   ({in_payload_i, sb_in}),
        .out_valid_o (head_valid),
        .out_ready_i (out_ready_i),
        .out_data_o  (head_entry)
    );

    assign head_payload = head_entry[ENTRY_W-1:SIDEBAND_W];
    assign head_sb      = head_entry[SIDEBAND_W-1:0];

    // Mask stale register contents so an empty stage always looks like a NOP.
    assign out_valid_o   = head_valid;
    assign out_payload_o = head_valid ? head_payload : BUBBLE;
    assign out_rd_o      = head_valid ? RD_W'(head_sb.rd) : '0;
    assign out_we_o      = head_valid && head_sb.we;
    assign out_is_load_o = head_valid && head_sb.is_load;
    assign load_use_o    = head_valid &&
                           load_use_hit(head_sb, REG_IDX_W'(rs1_i), REG_IDX_W'(rs2_i));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (head_valid && !out_ready_i && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, random traffic against a
// queue-based reference, then counter saturation and reset corner cases.
module tb_pipe_stage_reg;

    localparam int PW      = 128;
    localparam int RW      = 5;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam logic [PW-1:0] BUBBLE = 128'h13;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [PW-1:0] in_payload_i = '0;
    logic [RW-1:0] in_rd_i = '0;
    logic          in_we_i = 1'b0;
    logic          in_is_load_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [RW-1:0] rs1_i = '0;
    logic [RW-1:0] rs2_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [PW-1:0] out_payload_o;
    logic [RW-1:0] out_rd_o;
    logic          out_we_o;
    logic          out_is_load_o;
    logic          load_use_o;
    logic [CW-1:0] stall_cnt_o;

    always #5 clk_i = ~clk_i;

    pipe_stage_reg #(
        .PAYLOAD_W (PW),
        .RD_W      (RW),
        .SKID_EN   (1'b1),
        .BUBBLE    (BUBBLE),
        .CNT_W     (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_payload_i  (in_payload_i),
        .in_rd_i       (in_rd_i),
        .in_we_i       (in_we_i),
        .in_is_load_i  (in_is_load_i),
        .flush_i       (flush_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_payload_o (out_payload_o),
        .out_rd_o      (out_rd_o),
        .out_we_o      (out_we_o),
        .out_is_load_o (out_is_load_o),
        .load_use_o    (load_use_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    // Reference: an ordered list of held entries, at most two deep.
    typedef struct packed {
        logic [PW-1:0] pl;
        logic [RW-1:0] rd;
        logic          we;
        logic          ld;
    } ent_t;

    localparam ent_t EMPTY_ENT = '{pl: BUBBLE, rd: '0, we: 1'b0, ld: 1'b0};

    ent_t q[$];
    bit   m_ready = 1'b1;
    int   m_cnt = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        logic        v;
        logic [31:0] pl;
        logic [4:0]  rd;
        logic        we, ld, fl, ordy;
        logic [4:0]  rs1, rs2;
        logic        e_ov;
        logic [31:0] e_pl;
        logic        e_ir, e_lu;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [31:0] pl, input logic [4:0] rd,
                                input logic we, input logic ld, input logic fl, input logic ordy,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic e_ov, input logic [31:0] e_pl,
                                input logic e_ir, input logic e_lu);
        vec_t r;
        r.v = v; r.pl = pl; r.rd = rd; r.we = we; r.ld = ld; r.fl = fl; r.ordy = ordy;
        r.rs1 = rs1; r.rs2 = rs2; r.e_ov = e_ov; r.e_pl = e_pl; r.e_ir = e_ir; r.e_lu = e_lu;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all();
        ent_t h;
        bit   hv;
        bit   lu;
        hv = (q.size() > 0);
        h  = hv ? q[0] : EMPTY_ENT;
        lu = hv && h.ld && h.we && (h.rd != 0) && ((h.rd == rs1_i) || (h.rd == rs2_i));
        chk("out_valid", out_valid_o, hv);
        chk("out_payload", out_payload_o, h.pl);
        chk("out_rd", out_rd_o, h.rd);
        chk("out_we", out_we_o, h.we);
        chk("out_is_load", out_is_load_o, h.ld);
        chk("in_ready", in_ready_o, m_ready);
        chk("load_use", load_use_o, lu);
        chk("stall_cnt", stall_cnt_o, m_cnt);
    endtask

    task automatic model_edge();
        bit   hv, inf, outf;
        ent_t e;
        hv   = (q.size() > 0);
        inf  = in_valid_i && m_ready;
        outf = hv && out_ready_i;
        if (hv && !out_ready_i && m_cnt < CNT_MAX) m_cnt++;
        if (flush_i) begin
            q.delete();
        end else begin
            if (outf) void'(q.pop_front());
            if (inf) begin
                e.pl = in_payload_i; e.rd = in_rd_i; e.we = in_we_i; e.ld = in_is_load_i;
                q.push_back(e);
            end
        end
        m_ready = (q.size() < 2);
    endtask

    task automatic drive(input logic v, input logic [PW-1:0] pl, input logic [4:0] rd,
                         input logic we, input logic ld, input logic fl, input logic ordy,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        in_valid_i = v; in_payload_i = pl; in_rd_i = rd; in_we_i = we; in_is_load_i = ld;
        flush_i = fl; out_ready_i = ordy; rs1_i = rs1; rs2_i = rs2;
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        q.delete();
        m_ready = 1'b1;
        m_cnt   = 0;
        check_all();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        // idle
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h13, 1, 0));
        // streaming 1..8 with one-cycle latency
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(1, i, 0, 0, 0, 0, 1, 0, 0, i > 1, (i > 1) ? i - 1 : 32'h13, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h8, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h13, 1, 0));
        // back-pressure: A, B fill both entries, C is held off
        tbl.push_back(mk(1, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0, 32'h13, 1, 0));
        tbl.push_back(mk(1, 32'hB, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA, 1, 0));
        tbl.push_back(mk(1, 32'hC, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA, 0, 0));
        tbl.push_back(mk(1, 32'hC, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hA, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hB, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h13, 1, 0));
        // flush while full with a new entry offered
        tbl.push_back(mk(1, 32'h21, 0, 0, 0, 0, 0, 0, 0, 0, 32'h13, 1, 0));
        tbl.push_back(mk(1, 32'h22, 0, 0, 0, 0, 0, 0, 0, 1, 32'h21, 1, 0));
        tbl.push_back(mk(1, 32'h23, 0, 0, 0, 1, 0, 0, 0, 1, 32'h21, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h13, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h13, 1, 0));
        // load-use: rd 5 load, then rd 0, then we 0, then empty
        tbl.push_back(mk(1, 32'h31, 5, 1, 1, 0, 0, 5, 0, 0, 32'h13, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 32'h31, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 32'h31, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6, 7, 1, 32'h31, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 32'h31, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 32'h13, 1, 0));
        tbl.push_back(mk(1, 32'h32, 0, 1, 1, 0, 0, 0, 0, 0, 32'h13, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h32, 1, 0));
        tbl.push_back(mk(1, 32'h33, 7, 0, 1, 0, 0, 7, 0, 0, 32'h13, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 32'h33, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h13, 1, 0));

        // reset state
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_payload", out_payload_o, BUBBLE);
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        check_all();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        foreach (tbl[i]) begin
            drive(tbl[i].v, PW'(tbl[i].pl), tbl[i].rd, tbl[i].we, tbl[i].ld, tbl[i].fl,
                  tbl[i].ordy, tbl[i].rs1, tbl[i].rs2);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), out_valid_o, tbl[i].e_ov);
            chk($sformatf("tbl%0d_payload", i), out_payload_o, PW'(tbl[i].e_pl));
            chk($sformatf("tbl%0d_in_ready", i), in_ready_o, tbl[i].e_ir);
            chk($sformatf("tbl%0d_load_use", i), load_use_o, tbl[i].e_lu);
            check_all();
            tick();
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, {$urandom, $urandom, $urandom, $urandom},
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            #1;
            check_all();
            tick();
        end

        // reset with an entry held, then counter saturation from zero
        drive(1, 128'h77, 3, 1, 1, 0, 0, 0, 0);
        #1;
        check_all();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 3, 0);
        do_reset();
        #1;
        chk("midrst_out_valid", out_valid_o, 1'b0);
        chk("midrst_stall_cnt", stall_cnt_o, 0);
        check_all();
        drive(1, 128'h55, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_all();
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            check_all();
            tick();
        end
        #1;
        chk("cnt_saturated", stall_cnt_o, CNT_MAX);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        check_all();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("cnt_after_flush", stall_cnt_o, CNT_MAX);
        chk("flush_out_valid", out_valid_o, 1'b0);
        check_all();
        do_reset();
        #1;
        chk("cnt_after_reset", stall_cnt_o, 0);
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
